// File: rtl/display_decoder_if.sv
// Display bus seen by the decoder: the multiplexed DIG/SEG lines coming in,
// and the reconstructed digit data going out.
//   DIG[3:0]      digit select, active-low (asynchronous source)
//   SEG[6:0]      segments a..g, active-low (asynchronous source)
//   VALUE[15:0]   decoded digits, nibble i = digit i
//   DIGIT_OK[3:0] last sample of digit i was a legal hex pattern
//   BLANK[3:0]    last sample of digit i had all segments off
//   FRAME_VALID   one-cycle pulse when all four digits have been sampled
//   STALE         no sample for TIMEOUT_CYCLES cycles
// master = the side driving the display lines, slave = the decoder.
interface display_decoder_if;
   logic [3:0]  DIG;
   logic [6:0]  SEG;
   logic [15:0] VALUE;
   logic [3:0]  DIGIT_OK;
   logic [3:0]  BLANK;
   logic        FRAME_VALID;
   logic        STALE;

   modport master (output DIG, SEG,
                   input  VALUE, DIGIT_OK, BLANK, FRAME_VALID, STALE);
   modport slave  (input  DIG, SEG,
                   output VALUE, DIGIT_OK, BLANK, FRAME_VALID, STALE);
endinterface

// File: rtl/display_decoder.sv
// Reconstructs the hex value shown on a multiplexed 4-digit 7-segment display.
// The DIG/SEG pair is double-synchronized, must stay unchanged for
// SETTLE_CYCLES observations before it is committed to the digit it selects,
// and is then held until the pair changes again.
//   CLOCK_50MHZ  system clock, rising edge
//   RESET        synchronous, active-high
//   bus          display_decoder_if.slave (DIG/SEG in, decoded data out)
module display_decoder #(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 500000
) (
   input  logic               CLOCK_50MHZ,
   input  logic               RESET,
   display_decoder_if.slave   bus
);
   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [10:0] IDLE_PAIR = 11'h7FF;

   typedef enum logic [1:0] {IDLE, SETTLING, SAMPLED} state_t;

   // Pairs are packed as {DIG, SEG}.
   logic [10:0]   sync1, sync2, s_prev;
   state_t        state;
   logic [CW-1:0] cnt;
   logic [TW-1:0] tcnt;
   logic [3:0]    seen;
   logic [15:0]   value_r;
   logic [3:0]    ok_r, blank_r;
   logic          frame_r, stale_r;

   logic [2:0]    zeros;
   logic [1:0]    idx;
   logic          legal, changed, restart, active, commit;
   logic [CW-1:0] next_cnt;
   logic          hex_ok;
   logic [3:0]    hex_val;
   logic [3:0]    seen_n;

   always_comb begin
      zeros = '0;
      idx   = '0;
      for (int i = 0; i < 4; i++) begin
         if (!sync2[7+i]) begin
            zeros = zeros + 3'd1;
            idx   = 2'(i);
         end
      end
      legal   = (zeros == 3'd1);
      changed = (sync2 != s_prev);
      // Any change, or leaving IDLE, starts a fresh settle run at count 0.
      // A held pair in SAMPLED is never resampled.
      restart  = (state == IDLE) || changed;
      active   = legal && !(state == SAMPLED && !changed);
      next_cnt = restart ? '0 : cnt + 1'b1;
      commit   = active && (next_cnt == CW'(SETTLE_CYCLES - 1));
      seen_n   = seen | (4'b0001 << idx);
   end

   always_comb begin
      hex_ok  = 1'b1;
      hex_val = 4'h0;
      case (sync2[6:0])
         7'b1000000: hex_val = 4'h0;
         7'b1111001: hex_val = 4'h1;
         7'b0100100: hex_val = 4'h2;
         7'b0110000: hex_val = 4'h3;
         7'b0011001: hex_val = 4'h4;
         7'b0010010: hex_val = 4'h5;
         7'b0000010: hex_val = 4'h6;
         7'b1111000: hex_val = 4'h7;
         7'b0000000: hex_val = 4'h8;
         7'b0010000: hex_val = 4'h9;
         7'b0001000: hex_val = 4'hA;
         7'b0000011: hex_val = 4'hB;
         7'b1000110: hex_val = 4'hC;
         7'b0100001: hex_val = 4'hD;
         7'b0000110: hex_val = 4'hE;
         7'b0001110: hex_val = 4'hF;
         default:    hex_ok  = 1'b0;
      endcase
   end

   always_ff @(posedge CLOCK_50MHZ) begin
      if (RESET) begin
         sync1   <= IDLE_PAIR;
         sync2   <= IDLE_PAIR;
         s_prev  <= IDLE_PAIR;
         state   <= IDLE;
         cnt     <= '0;
         tcnt    <= '0;
         seen    <= '0;
         value_r <= '0;
         ok_r    <= '0;
         blank_r <= '0;
         frame_r <= 1'b0;
         stale_r <= 1'b0;
      end else begin
         sync1   <= {bus.DIG, bus.SEG};
         sync2   <= sync1;
         s_prev  <= sync2;
         frame_r <= 1'b0;

         if (!legal) begin
            state <= IDLE;
            cnt   <= '0;
         end else if (commit) begin
            state <= SAMPLED;
            cnt   <= '0;
         end else if (active) begin
            state <= SETTLING;
            cnt   <= next_cnt;
         end

         if (commit) begin
            if (hex_ok) value_r[idx*4 +: 4] <= hex_val;
            ok_r[idx]    <= hex_ok;
            blank_r[idx] <= (sync2[6:0] == 7'h7F);
            if (&seen_n) begin
               frame_r <= 1'b1;
               seen    <= '0;
            end else begin
               seen    <= seen_n;
            end
            tcnt    <= '0;
            stale_r <= 1'b0;
         end else begin
            if (tcnt != TW'(TIMEOUT_CYCLES)) tcnt <= tcnt + 1'b1;
            if (tcnt >= TW'(TIMEOUT_CYCLES - 1)) stale_r <= 1'b1;
         end
      end
   end

   assign bus.VALUE       = value_r;
   assign bus.DIGIT_OK    = ok_r;
   assign bus.BLANK       = blank_r;
   assign bus.FRAME_VALID = frame_r;
   assign bus.STALE       = stale_r;
endmodule

// File: tb/tb_display_decoder.sv
// Bench for display_decoder: directed scenarios followed by random display
// traffic, all checked every cycle against a run-length reference model.
module tb_display_decoder;
   localparam int ST = 4;
   localparam int TO = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;

   display_decoder_if bus ();

   display_decoder #(.SETTLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)) dut (
      .CLOCK_50MHZ (clk),
      .RESET       (rst),
      .bus         (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int fcnt    = 0;
   bit mon_en  = 1'b0;

   logic [6:0] hex_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: the FSM observes the input pair two edges late, and a
   // digit is committed once per run of identical legal observations, on the
   // observation that makes the run SETTLE_CYCLES long.
   logic [10:0] m_s1, m_s2, obs_prev;
   int          run;
   logic [15:0] m_val;
   logic [3:0]  m_ok, m_blank, m_seen;
   logic        m_frame, m_stale;
   int          m_idle;

   always @(posedge clk) begin
      logic [10:0] obs;
      int d, hit;
      if (rst) begin
         m_s1 = 11'h7FF; m_s2 = 11'h7FF; obs_prev = 11'h7FF; run = 0;
         m_val = '0; m_ok = '0; m_blank = '0; m_seen = '0;
         m_frame = 0; m_stale = 0; m_idle = 0;
      end else begin
         obs = m_s2;
         run = (obs == obs_prev) ? run + 1 : 1;
         if (run > 1000) run = 1000;
         obs_prev = obs;
         m_frame = 0;
         d = -1;
         for (int i = 0; i < 4; i++) if (!obs[7+i]) d = i;
         if ($countones(obs[10:7]) == 3 && run == ST) begin
            hit = -1;
            for (int v = 0; v < 16; v++) if (hex_tab[v] == obs[6:0]) hit = v;
            if (hit >= 0) m_val[d*4 +: 4] = 4'(hit);
            m_ok[d]    = (hit >= 0);
            m_blank[d] = (obs[6:0] == 7'h7F);
            m_seen[d]  = 1'b1;
            if (m_seen == 4'hF) begin
               m_frame = 1;
               m_seen  = '0;
            end
            m_idle  = 0;
            m_stale = 0;
         end else begin
            if (m_idle < TO) m_idle++;
            m_stale = (m_idle == TO);
         end
         m_s2 = m_s1;
         m_s1 = {bus.DIG, bus.SEG};
      end
   end

   always @(negedge clk) begin
      if (bus.FRAME_VALID === 1'b1) fcnt++;
      if (mon_en) begin
         chk("value", bus.VALUE, m_val);
         chk("digit_ok", bus.DIGIT_OK, m_ok);
         chk("blank", bus.BLANK, m_blank);
         chk("frame_valid", bus.FRAME_VALID, m_frame);
         chk("stale", bus.STALE, m_stale);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic [3:0] dig, input logic [6:0] seg);
      bus.DIG = dig;
      bus.SEG = seg;
   endtask

   initial begin
      int f0;
      drive(4'hF, 7'h7F);
      step(3);
      rst = 1'b0;
      mon_en = 1'b1;

      // Idle bus: everything stays at reset values until the timeout.
      chk("rst_value", bus.VALUE, 16'h0);
      chk("rst_stale", bus.STALE, 1'b0);
      f0 = fcnt;
      step(63);
      chk("stale_early", bus.STALE, 1'b0);
      step(1);
      chk("stale_set", bus.STALE, 1'b1);
      chk("idle_no_frame", fcnt - f0, 0);

      // Single digit, latency.
      drive(4'hE, 7'h12);
      step(5);
      chk("lat_before", bus.VALUE, 16'h0);
      step(1);
      chk("lat_value", bus.VALUE, 16'h0005);
      chk("lat_ok", bus.DIGIT_OK, 4'b0001);
      chk("lat_stale_clr", bus.STALE, 1'b0);
      step(4);

      // Full frame of 1,2,3,F.
      f0 = fcnt;
      drive(4'hE, hex_tab[1]);  step(10);
      drive(4'hD, hex_tab[2]);  step(10);
      drive(4'hB, hex_tab[3]);  step(10);
      drive(4'h7, hex_tab[15]); step(10);
      chk("frame_value", bus.VALUE, 16'hF321);
      chk("frame_ok", bus.DIGIT_OK, 4'hF);
      chk("frame_pulses", fcnt - f0, 1);

      // Blank then garbage on digit 1.
      drive(4'hD, 7'h7F); step(10);
      chk("blank_set", bus.BLANK, 4'b0010);
      chk("blank_ok", bus.DIGIT_OK, 4'b1101);
      chk("blank_value", bus.VALUE, 16'hF321);
      drive(4'hD, 7'h36); step(10);
      chk("junk_blank", bus.BLANK, 4'b0000);
      chk("junk_ok", bus.DIGIT_OK, 4'b1101);
      chk("junk_value", bus.VALUE, 16'hF321);

      // Illegal select, then a short glitch on a settled digit.
      drive(4'hC, hex_tab[8]); step(20);
      chk("illegal_value", bus.VALUE, 16'hF321);
      drive(4'hB, hex_tab[7]); step(10);
      drive(4'hB, hex_tab[8]); step(2);
      drive(4'hB, hex_tab[7]); step(10);
      chk("glitch_value", bus.VALUE, 16'hF721);

      // Reset in the middle of a settle run.
      drive(4'h7, hex_tab[8]); step(5);
      rst = 1'b1; step(1); rst = 1'b0;
      chk("midrst_value", bus.VALUE, 16'h0);
      chk("midrst_ok", bus.DIGIT_OK, 4'h0);
      step(4);
      chk("midrst_nocommit", bus.VALUE, 16'h0);
      step(3);
      chk("midrst_restart", bus.VALUE, 16'h8000);

      // Random display traffic.
      for (int k = 0; k < 400; k++) begin
         int r, d;
         logic [3:0] dig;
         logic [6:0] seg;
         r = $urandom_range(0, 19);
         d = $urandom_range(0, 3);
         dig = 4'hF;
         dig[d] = 1'b0;
         seg = hex_tab[$urandom_range(0, 15)];
         if (r == 0) begin
            rst = 1'b1; step($urandom_range(1, 2)); rst = 1'b0;
         end else begin
            if (r == 1) dig = 4'($urandom_range(0, 15));
            if (r == 2) seg = 7'h7F;
            if (r == 3) seg = 7'($urandom_range(0, 127));
            drive(dig, seg);
            step((r == 4) ? 70 : $urandom_range(1, 10));
         end
      end

      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/display_decoder.md
Name: display_decoder

Overview:
- Monitors a multiplexed 4-digit, 7-segment display bus (DIG, SEG), as produced by the team's display controller, and reconstructs the hexadecimal value shown on each digit.
- Used as a checker in display benches and to read external multiplexed displays on the board.
- Output is a 16-bit value, per-digit status, a frame-complete pulse and a staleness flag.

Parameters:
SETTLE_CYCLES, 4, consecutive cycles the synchronized DIG/SEG pair must be unchanged before it is sampled (legal range >=1).
TIMEOUT_CYCLES, 500000, cycles without any sample before STALE asserts (>=2).

Ports:
CLOCK_50MHZ  input  1  system clock, rising edge.
RESET  input  1  synchronous, active-high reset.
DIG  input  4  digit select, active-low, asynchronous to CLOCK_50MHZ; bit i low selects digit i.
SEG  input  7  segments, active-low, bit0=a .. bit6=g, asynchronous.
VALUE  output  16  decoded digits; VALUE[4i+3:4i] = digit i.
DIGIT_OK  output  4  bit i = last sample of digit i was a legal hex pattern.
BLANK  output  4  bit i = last sample of digit i was all segments off (1111111).
FRAME_VALID  output  1  one-cycle pulse when all 4 digits have been sampled since the last pulse.
STALE  output  1  high while no sample has occurred for TIMEOUT_CYCLES cycles.

Behaviour:
- Reset (on a RESET-high clock edge): VALUE=0, DIGIT_OK=0, BLANK=0, FRAME_VALID=0, STALE=0, seen mask=0, settle counter=0, timeout counter=0. Both sync stages load DIG=1111 and SEG=1111111. FSM goes to IDLE. RESET overrides every event in the same cycle, including one mid-settle; the sample in progress is discarded.
- Synchronizer: two flops on DIG and SEG. Edge 0 captures a new input, and edge 1 presents it as the synchronized pair S.
- Legal select: exactly one bit of S.DIG is 0. Any other select (1111, or two or more low) is illegal.
- FSM states:
  - IDLE: S is illegal. Go to SETTLING with count=0 when S is legal.
  - SETTLING: if S differs from the previous edge, count=0 (go to IDLE if S is now illegal). Otherwise count++. When count reaches SETTLE_CYCLES-1 with S unchanged, commit the sample and go to SAMPLED.
  - SAMPLED: hold with no resampling. Any change in S sends the FSM to SETTLING with count=0, or to IDLE if S is illegal.
- Latency: with inputs constant from edge 0, the commit is visible on the outputs after edge SETTLE_CYCLES+1.
- Commit for selected digit i:
  - Hex patterns (gfedcba, active-low):
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000
    - 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000, A=0001000, b=0000011
    - C=1000110, d=0100001, E=0000110, F=0001110
  - Hex match: nibble i = decoded value, DIGIT_OK[i]=1, BLANK[i]=0.
  - 1111111: nibble i unchanged, DIGIT_OK[i]=0, BLANK[i]=1.
  - Any other pattern: nibble i unchanged, DIGIT_OK[i]=0, BLANK[i]=0.
  - Every commit sets seen[i], clears the timeout counter and clears STALE.
- Frame: on the commit that makes seen=1111, FRAME_VALID=1 for exactly one cycle and seen clears in the same edge. Re-sampling a digit already in seen only overwrites its data; the mask is unchanged.
- Timeout counter: increments every non-commit cycle and saturates at TIMEOUT_CYCLES. STALE=1 once the counter reaches TIMEOUT_CYCLES, held until the next commit. A commit on the saturation edge wins: STALE stays 0.
- A glitch shorter than SETTLE_CYCLES between two identical patterns produces no commit. Both edges of the glitch restart the count.

Test Plan (SETTLE_CYCLES=4, TIMEOUT_CYCLES=64):
- Reset then idle (DIG=1111): all outputs 0; STALE=1 after 64 cycles; FRAME_VALID never pulses.
- Hold DIG=1110, SEG=0010010 from edge 0 -> VALUE=0x0005, DIGIT_OK=0001 after edge 5, no FRAME_VALID.
- Cycle digits 0..3 with patterns 1,2,3,F, each held 10 cycles -> VALUE=0xF321, DIGIT_OK=1111, one FRAME_VALID pulse on the digit-3 commit, seen cleared.
- Digit 1 shows 1111111, then 0110110 -> VALUE nibble 1 unchanged; BLANK=0010 then 0000; DIGIT_OK[1]=0 both times.
- DIG=1100 held 20 cycles, then a 2-cycle SEG glitch on a settled digit -> no commits; VALUE unchanged; count restarts.
- RESET asserted at count=2 during SETTLING -> all outputs 0, no commit for that digit; sampling restarts from IDLE.
